mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester and unified-memory signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              iFetchReq;
    logic [DATA_W-1:0] iFetchAddr;
    logic              oFetchDone;
    logic [DATA_W-1:0] oFetchData;

    logic              iDataReq;
    logic              iDataWe;
    logic [DATA_W-1:0] iDataAddr;
    logic [DATA_W-1:0] iDataWData;
    logic              oDataDone;
    logic [DATA_W-1:0] oDataRData;

    logic [DATA_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemWData;
    logic              oMemRead;
    logic              oMemWrite;
    logic [DATA_W-1:0] iMemRData;

    logic              oBusy;

    modport slave (
        input  iFetchReq, iFetchAddr,
        input  iDataReq, iDataWe, iDataAddr, iDataWData,
        input  iMemRData,
        output oFetchDone, oFetchData,
        output oDataDone, oDataRData,
        output oMemAddr, oMemWData, oMemRead, oMemWrite,
        output oBusy
    );

    modport master (
        output iFetchReq, iFetchAddr,
        output iDataReq, iDataWe, iDataAddr, iDataWData,
        output iMemRData,
        input  oFetchDone, oFetchData,
        input  oDataDone, oDataRData,
        input  oMemAddr, oMemWData, oMemRead, oMemWrite,
        input  oBusy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) round-robin arbiter onto one fixed-latency memory
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic         iClk,
    input  logic         iRst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    stateT             state;
    stateT             stateNext;
    logic              lastGnt;
    logic [3:0]        waitCnt;
    logic [DATA_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic              weQ;
    logic              ownerQ;
    logic              grant;
    logic              grantD;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // On a tie, the requester that did not win last time gets the grant
    always_comb begin
        stateNext      = state;
        grant          = 1'b0;
        grantD         = 1'b0;
        bus.oMemRead   = 1'b0;
        bus.oMemWrite  = 1'b0;
        bus.oFetchDone = 1'b0;
        bus.oDataDone  = 1'b0;
        case (state)
            IDLE: begin
                grant  = bus.iFetchReq | bus.iDataReq;
                grantD = bus.iDataReq & (~bus.iFetchReq | ~lastGnt);
                if (grant) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                bus.oMemRead  = ~weQ;
                bus.oMemWrite = weQ;
                if (waitCnt == 4'd0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                bus.oFetchDone = ~ownerQ;
                bus.oDataDone  = ownerQ;
                stateNext      = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            lastGnt <= 1'b1;
            waitCnt <= 4'd0;
            addrQ   <= '0;
            wdataQ  <= '0;
            rdataQ  <= '0;
            weQ     <= 1'b0;
            ownerQ  <= 1'b0;
        end else begin
            if (state == IDLE && grant) begin
                addrQ   <= grantD ? bus.iDataAddr : bus.iFetchAddr;
                weQ     <= grantD & bus.iDataWe;
                ownerQ  <= grantD;
                lastGnt <= grantD;
                waitCnt <= WAIT_LOAD;
                if (grantD) begin
                    wdataQ <= bus.iDataWData;
                end
            end
            if (state == ACCESS) begin
                if (waitCnt == 4'd0) begin
                    // Stores leave the response register alone so oDataRData is unchanged
                    if (!weQ) begin
                        rdataQ <= bus.iMemRData;
                    end
                end else begin
                    waitCnt <= waitCnt - 4'd1;
                end
            end
        end
    end

    // Memory side is fed only from latched registers
    assign bus.oMemAddr   = addrQ;
    assign bus.oMemWData  = wdataQ;
    assign bus.oFetchData = rdataQ;
    assign bus.oDataRData = rdataQ;
    assign bus.oBusy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(32)) b0 ();
    mem_arbiter_if #(.DATA_W(32)) b1 ();
    mem_arbiter_if #(.DATA_W(32)) b2 ();

    mem_arbiter #(.WAIT_CYCLES(2),  .DATA_W(32)) u0 (.iClk(clk), .iRst(rst), .bus(b0.slave));
    mem_arbiter #(.WAIT_CYCLES(1),  .DATA_W(32)) u1 (.iClk(clk), .iRst(rst), .bus(b1.slave));
    mem_arbiter #(.WAIT_CYCLES(15), .DATA_W(32)) u2 (.iClk(clk), .iRst(rst), .bus(b2.slave));

    // One writable word plus fixed contents at 0x10
    logic [31:0] memWord     = 32'h0;
    logic [31:0] memWordAddr = 32'h0;
    always @(posedge clk) begin
        if (b0.oMemWrite) begin
            memWordAddr <= b0.oMemAddr;
            memWord     <= b0.oMemWData;
        end
    end
    assign b0.iMemRData = (b0.oMemAddr == memWordAddr) ? memWord :
                          (b0.oMemAddr == 32'h10) ? 32'h0010_0093 : (b0.oMemAddr ^ 32'h5A5A_5A5A);
    assign b1.iMemRData = b1.oMemAddr ^ 32'hA5A5_0000;
    assign b2.iMemRData = b2.oMemAddr ^ 32'hA5A5_0000;

    int nCmp = 0;
    int nErr = 0;
    int ovl  = 0;

    always @(negedge clk) begin
        if ((b0.oFetchDone && b0.oDataDone) || (b0.oMemRead && b0.oMemWrite)) ovl++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit isD, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] expRd, input string tag);
        int lat   = -1;
        int rdCnt = 0;
        int wrCnt = 0;
        @(posedge clk); #1;
        if (isD) begin
            b0.iDataReq = 1'b1; b0.iDataWe = we; b0.iDataAddr = addr; b0.iDataWData = wdata;
        end else begin
            b0.iFetchReq = 1'b1; b0.iFetchAddr = addr;
        end
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) check({tag, "/idleAtReq"}, 32'(b0.oBusy), 32'h0);
            if (c == 1) begin
                b0.iFetchAddr = ~addr; b0.iDataAddr = ~addr;
                b0.iDataWData = ~wdata; b0.iDataWe = ~we;
            end
            if (b0.oMemRead || b0.oMemWrite) begin
                rdCnt += int'(b0.oMemRead);
                wrCnt += int'(b0.oMemWrite);
                check({tag, "/memAddr"}, b0.oMemAddr, addr);
                if (we) check({tag, "/memWData"}, b0.oMemWData, wdata);
            end
            if (b0.oFetchDone || b0.oDataDone) begin
                lat = c;
                check({tag, "/owner"}, 32'(b0.oDataDone), 32'(isD));
                check({tag, "/data"}, isD ? b0.oDataRData : b0.oFetchData, expRd);
                b0.iFetchReq = 1'b0;
                b0.iDataReq  = 1'b0;
            end
        end
        check({tag, "/latency"}, 32'(lat), 32'd3);
        check({tag, "/readCycles"}, 32'(rdCnt), we ? 32'd0 : 32'd2);
        check({tag, "/writeCycles"}, 32'(wrCnt), we ? 32'd2 : 32'd0);
    endtask

    initial begin
        int order [4];
        int tDone [4];
        int n;
        int tF, tD, l1, l2, dones;

        b0.iFetchReq = 0; b0.iFetchAddr = 0; b0.iDataReq = 0; b0.iDataWe = 0;
        b0.iDataAddr = 0; b0.iDataWData = 0;
        b1.iFetchReq = 0; b1.iFetchAddr = 0; b1.iDataReq = 0; b1.iDataWe = 0;
        b1.iDataAddr = 0; b1.iDataWData = 0;
        b2.iFetchReq = 0; b2.iFetchAddr = 0; b2.iDataReq = 0; b2.iDataWe = 0;
        b2.iDataAddr = 0; b2.iDataWData = 0;

        rst = 1'b1;
        #1;
        check("rst/busy", 32'(b0.oBusy), 32'h0);
        check("rst/memRead", 32'(b0.oMemRead), 32'h0);
        check("rst/memWrite", 32'(b0.oMemWrite), 32'h0);
        check("rst/fetchDone", 32'(b0.oFetchDone), 32'h0);
        check("rst/dataDone", 32'(b0.oDataDone), 32'h0);
        check("rst/memAddr", b0.oMemAddr, 32'h0);
        check("rst/fetchData", b0.oFetchData, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'h0010_0093, "fetch");
        @(negedge clk);
        check("hold/memAddr", b0.oMemAddr, 32'h10);
        check("hold/memRead", 32'(b0.oMemRead), 32'h0);
        xfer(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0010_0093, "store");
        xfer(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, "load");

        // Both requesters held from the first cycle after reset
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        b0.iFetchReq = 1; b0.iFetchAddr = 32'h10;
        b0.iDataReq = 1; b0.iDataWe = 0; b0.iDataAddr = 32'h100;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (b0.oFetchDone || b0.oDataDone) begin
                order[n] = int'(b0.oDataDone);
                tDone[n] = c;
                n++;
                if (n == 4) begin b0.iFetchReq = 0; b0.iDataReq = 0; end
            end
        end
        check("alt/count", 32'(n), 32'd4);
        check("alt/owner0", 32'(order[0]), 32'd0);
        check("alt/owner1", 32'(order[1]), 32'd1);
        check("alt/owner2", 32'(order[2]), 32'd0);
        check("alt/owner3", 32'(order[3]), 32'd1);
        check("alt/time0", 32'(tDone[0]), 32'd3);
        check("alt/time1", 32'(tDone[1]), 32'd7);
        check("alt/time2", 32'(tDone[2]), 32'd11);
        check("alt/time3", 32'(tDone[3]), 32'd15);

        // D arrives while F is in ACCESS
        @(posedge clk); #1;
        b0.iFetchReq = 1; b0.iFetchAddr = 32'h10;
        tF = -1; tD = -1;
        for (int c = 0; c < 40 && tD < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                b0.iDataReq = 1; b0.iDataWe = 0; b0.iDataAddr = 32'h100;
            end
            if (b0.oFetchDone) begin tF = c; b0.iFetchReq = 0; end
            if (b0.oDataDone) begin
                tD = c; b0.iDataReq = 0;
                check("late/dData", b0.oDataRData, 32'hDEAD_BEEF);
            end
        end
        check("late/fDone", 32'(tF), 32'd3);
        check("late/dDone", 32'(tD), 32'd7);

        // Asynchronous reset in the middle of ACCESS
        @(posedge clk); #1;
        b0.iFetchReq = 1; b0.iFetchAddr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        check("arst/inAccess", 32'(b0.oMemRead), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst/memRead", 32'(b0.oMemRead), 32'h0);
        check("arst/busy", 32'(b0.oBusy), 32'h0);
        check("arst/memAddr", b0.oMemAddr, 32'h0);
        b0.iFetchReq = 0;
        @(negedge clk) rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (b0.oFetchDone || b0.oDataDone) dones++;
        end
        check("arst/noDone", 32'(dones), 32'h0);
        @(posedge clk); #1;
        b0.iFetchReq = 1; b0.iDataReq = 1; b0.iDataWe = 0;
        n = -1;
        for (int c = 0; c < 40 && n < 0; c++) begin
            @(negedge clk);
            if (b0.oFetchDone || b0.oDataDone) begin
                n = int'(b0.oDataDone);
                b0.iFetchReq = 0; b0.iDataReq = 0;
            end
        end
        check("arst/firstOwner", 32'(n), 32'd0);

        // Latency at the WAIT_CYCLES extremes
        @(posedge clk); #1;
        b1.iFetchReq = 1; b1.iFetchAddr = 32'h40;
        b2.iFetchReq = 1; b2.iFetchAddr = 32'h80;
        l1 = -1; l2 = -1;
        for (int c = 0; c < 40 && (l1 < 0 || l2 < 0); c++) begin
            @(negedge clk);
            if (b1.oFetchDone && l1 < 0) begin
                l1 = c; b1.iFetchReq = 0;
                check("w1/data", b1.oFetchData, 32'hA5A5_0040);
            end
            if (b2.oFetchDone && l2 < 0) begin
                l2 = c; b2.iFetchReq = 0;
                check("w15/data", b2.oFetchData, 32'hA5A5_0080);
            end
        end
        check("w1/latency", 32'(l1), 32'd2);
        check("w15/latency", 32'(l2), 32'd16);

        check("exclusive", 32'(ovl), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
